// File: rtl/wb_regfile_pkg.sv
// Shared constants and stage-entry type for the M/W writeback pipeline.
package wb_regfile_pkg;
  localparam int RegBus     = 32;
  localparam int RegAddrBus = 5;
  localparam int RegNum     = 32;

  localparam logic [RegBus-1:0]     ZeroWord    = {RegBus{1'b0}};
  localparam logic                  RstEnable   = 1'b1;
  localparam logic                  WriteEnable = 1'b1;
  localparam logic [RegAddrBus-1:0] NOPRegAddr  = {RegAddrBus{1'b0}};

  typedef struct packed {
    logic                  wreg;
    logic [RegAddrBus-1:0] wd;
    logic [RegBus-1:0]     wdata;
  } stage_t;

  localparam stage_t Bubble = '0;
endpackage

// File: rtl/wb_regfile_regfile.sv
// 32x32 register array: one synchronous write port, two combinational reads.
module regfile
  import wb_regfile_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [RegAddrBus-1:0] waddr,
  input  logic [RegBus-1:0]     wdata,
  input  logic [RegAddrBus-1:0] raddr1,
  input  logic [RegAddrBus-1:0] raddr2,
  output logic [RegBus-1:0]     rdata1,
  output logic [RegBus-1:0]     rdata2
);
  logic [RegBus-1:0] regs [RegNum];

  // Entry 0 is never written, so it stays at its reset value.
  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      for (int i = 0; i < RegNum; i++) regs[i] <= ZeroWord;
    end else if (we == WriteEnable && waddr != NOPRegAddr) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata1 = (raddr1 == NOPRegAddr) ? ZeroWord : regs[raddr1];
  assign rdata2 = (raddr2 == NOPRegAddr) ? ZeroWord : regs[raddr2];
endmodule

// File: rtl/wb_regfile.sv
// M/W writeback pipeline in front of the register array, with full bypass
// from the execute input, M and W onto both read ports.
module wb_regfile
  import wb_regfile_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [RegAddrBus-1:0] wd_i,
  input  logic                  wreg_i,
  input  logic [RegBus-1:0]     wdata_i,
  input  logic                  stall_i,
  input  logic                  flush_i,
  input  logic                  re1_i,
  input  logic [RegAddrBus-1:0] raddr1_i,
  input  logic                  re2_i,
  input  logic [RegAddrBus-1:0] raddr2_i,
  output logic [RegBus-1:0]     rdata1_o,
  output logic [RegBus-1:0]     rdata2_o,
  output logic                  wb_wreg_o,
  output logic [RegAddrBus-1:0] wb_wd_o,
  output logic [RegBus-1:0]     wb_wdata_o
);
  stage_t ex, m, w;
  logic [RegBus-1:0] arr1, arr2;

  assign ex = '{wreg: wreg_i, wd: wd_i, wdata: wdata_i};

  // W always drains into the array; stall only freezes M and starves W.
  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      m <= Bubble;
      w <= Bubble;
    end else if (flush_i) begin
      m <= Bubble;
      w <= Bubble;
    end else if (stall_i) begin
      w <= Bubble;
    end else begin
      m <= ex;
      w <= m;
    end
  end

  regfile u_regfile (
    .clk    (clk),
    .rst    (rst),
    .we     (w.wreg),
    .waddr  (w.wd),
    .wdata  (w.wdata),
    .raddr1 (raddr1_i),
    .raddr2 (raddr2_i),
    .rdata1 (arr1),
    .rdata2 (arr2)
  );

  function automatic logic [RegBus-1:0] fwd(
    input logic                  r,
    input logic                  re,
    input logic [RegAddrBus-1:0] a,
    input stage_t                e,
    input stage_t                mm,
    input stage_t                ww,
    input logic [RegBus-1:0]     arr
  );
    if (r == RstEnable || !re || a == NOPRegAddr) return ZeroWord;
    if (e.wreg == WriteEnable && e.wd == a)       return e.wdata;
    if (mm.wreg == WriteEnable && mm.wd == a)     return mm.wdata;
    if (ww.wreg == WriteEnable && ww.wd == a)     return ww.wdata;
    return arr;
  endfunction

  assign rdata1_o = fwd(rst, re1_i, raddr1_i, ex, m, w, arr1);
  assign rdata2_o = fwd(rst, re2_i, raddr2_i, ex, m, w, arr2);

  assign wb_wreg_o  = w.wreg;
  assign wb_wd_o    = w.wd;
  assign wb_wdata_o = w.wdata;
endmodule

// File: tb/tb_wb_regfile.sv
// Bench for wb_regfile: directed vector table, hand sequences for stall/flush,
// and random traffic against an in-flight-queue reference model.
module tb_wb_regfile;
  typedef struct packed {
    logic        rst, wreg;
    logic [4:0]  wd;
    logic [31:0] wdata;
    logic        stall, flush, re1;
    logic [4:0]  ra1;
    logic        re2;
    logic [4:0]  ra2;
  } stim_t;

  typedef struct packed {
    stim_t       s;
    logic [31:0] rd1, rd2;
    logic        wbw;
    logic [4:0]  wbd;
    logic [31:0] wbdata;
  } vec_t;

  typedef struct packed {
    logic        wreg;
    logic [4:0]  wd;
    logic [31:0] wdata;
  } ent_t;

  logic clk = 1'b0;
  logic rst, wreg_i, stall_i, flush_i, re1_i, re2_i;
  logic [4:0]  wd_i, raddr1_i, raddr2_i;
  logic [31:0] wdata_i;
  logic [31:0] rdata1_o, rdata2_o;
  logic        wb_wreg_o;
  logic [4:0]  wb_wd_o;
  logic [31:0] wb_wdata_o;

  int n_cmp = 0, n_bad = 0;
  logic [31:0] rd1_s, rd2_s;

  // Reference: register contents plus a queue of in-flight writes, youngest first.
  logic [31:0] mregs [32];
  ent_t inflight[$];
  localparam ent_t BUB = '0;

  always #5 clk = ~clk;

  wb_regfile dut (
    .clk(clk), .rst(rst), .wd_i(wd_i), .wreg_i(wreg_i), .wdata_i(wdata_i),
    .stall_i(stall_i), .flush_i(flush_i), .re1_i(re1_i), .raddr1_i(raddr1_i),
    .re2_i(re2_i), .raddr2_i(raddr2_i), .rdata1_o(rdata1_o), .rdata2_o(rdata2_o),
    .wb_wreg_o(wb_wreg_o), .wb_wd_o(wb_wd_o), .wb_wdata_o(wb_wdata_o)
  );

  function automatic stim_t st(input logic r, wr, input logic [4:0] d, input logic [31:0] dat,
                               input logic sl, fl, e1, input logic [4:0] a1,
                               input logic e2, input logic [4:0] a2);
    stim_t s;
    s.rst = r; s.wreg = wr; s.wd = d; s.wdata = dat; s.stall = sl; s.flush = fl;
    s.re1 = e1; s.ra1 = a1; s.re2 = e2; s.ra2 = a2;
    return s;
  endfunction

  function automatic vec_t mkv(input stim_t s, input logic [31:0] r1, r2,
                               input logic w, input logic [4:0] d, input logic [31:0] dat);
    vec_t v;
    v.s = s; v.rd1 = r1; v.rd2 = r2; v.wbw = w; v.wbd = d; v.wbdata = dat;
    return v;
  endfunction

  function automatic stim_t idle(input logic e1, input logic [4:0] a1,
                                 input logic e2, input logic [4:0] a2);
    return st(0, 0, 0, 0, 0, 0, e1, a1, e2, a2);
  endfunction

  function automatic logic [31:0] model_read(input logic re, input logic [4:0] ra, input stim_t s);
    if (s.rst || !re || ra == 0) return 0;
    if (s.wreg && s.wd == ra) return s.wdata;
    foreach (inflight[i]) if (inflight[i].wreg && inflight[i].wd == ra) return inflight[i].wdata;
    return mregs[ra];
  endfunction

  task automatic model_edge(input stim_t s);
    ent_t oldest, nw;
    if (s.rst) begin
      foreach (mregs[i]) mregs[i] = 0;
      inflight = {BUB, BUB};
    end else begin
      oldest = inflight[1];
      if (oldest.wreg && oldest.wd != 0) mregs[oldest.wd] = oldest.wdata;
      if (s.flush) inflight = {BUB, BUB};
      else if (s.stall) inflight[1] = BUB;
      else begin
        nw.wreg = s.wreg; nw.wd = s.wd; nw.wdata = s.wdata;
        void'(inflight.pop_back());
        inflight.push_front(nw);
      end
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // One clock: drive, check reads before the edge, check W after the edge.
  task automatic cyc(input stim_t s);
    rst = s.rst; wreg_i = s.wreg; wd_i = s.wd; wdata_i = s.wdata;
    stall_i = s.stall; flush_i = s.flush;
    re1_i = s.re1; raddr1_i = s.ra1; re2_i = s.re2; raddr2_i = s.ra2;
    #1;
    rd1_s = rdata1_o; rd2_s = rdata2_o;
    chk("model_rd1", rd1_s, model_read(s.re1, s.ra1, s));
    chk("model_rd2", rd2_s, model_read(s.re2, s.ra2, s));
    @(posedge clk);
    model_edge(s);
    #1;
    chk("model_wb_wreg",  {31'd0, wb_wreg_o}, {31'd0, inflight[1].wreg});
    chk("model_wb_wd",    {27'd0, wb_wd_o},   {27'd0, inflight[1].wd});
    chk("model_wb_wdata", wb_wdata_o,         inflight[1].wdata);
  endtask

  vec_t tbl [16];
  int c7, c_aa;

  initial begin
    foreach (mregs[i]) mregs[i] = 0;
    inflight = {BUB, BUB};

    tbl[0]  = mkv(st(1,0,0,0,0,0,1,5,1,5),              0, 0, 0, 0, 0);
    tbl[1]  = mkv(st(0,1,5,32'hDEADBEEF,0,0,1,5,1,0),   32'hDEADBEEF, 0, 0, 0, 0);
    tbl[2]  = mkv(idle(1,5,0,0),                        32'hDEADBEEF, 0, 1, 5, 32'hDEADBEEF);
    tbl[3]  = mkv(idle(1,5,0,5),                        32'hDEADBEEF, 0, 0, 0, 0);
    tbl[4]  = mkv(idle(1,5,1,5),                        32'hDEADBEEF, 32'hDEADBEEF, 0, 0, 0);
    tbl[5]  = mkv(st(0,1,3,32'h11,0,0,1,3,0,0),         32'h11, 0, 0, 0, 0);
    tbl[6]  = mkv(st(0,1,3,32'h22,0,0,1,3,0,0),         32'h22, 0, 1, 3, 32'h11);
    tbl[7]  = mkv(st(0,1,3,32'h33,0,0,1,3,1,3),         32'h33, 32'h33, 1, 3, 32'h22);
    tbl[8]  = mkv(idle(1,3,1,5),                        32'h33, 32'hDEADBEEF, 1, 3, 32'h33);
    tbl[9]  = mkv(idle(1,3,0,0),                        32'h33, 0, 0, 0, 0);
    tbl[10] = mkv(st(0,1,0,32'hFFFFFFFF,0,0,1,0,0,0),   0, 0, 0, 0, 0);
    tbl[11] = mkv(idle(1,0,0,0),                        0, 0, 1, 0, 32'hFFFFFFFF);
    tbl[12] = mkv(idle(1,0,1,3),                        0, 32'h33, 0, 0, 0);
    tbl[13] = mkv(idle(1,0,1,0),                        0, 0, 0, 0, 0);
    tbl[14] = mkv(st(1,0,0,0,0,0,1,3,1,5),              0, 0, 0, 0, 0);
    tbl[15] = mkv(idle(1,3,1,5),                        0, 0, 0, 0, 0);

    for (int i = 0; i < 16; i++) begin
      cyc(tbl[i].s);
      chk($sformatf("vec%0d_rd1", i), rd1_s, tbl[i].rd1);
      chk($sformatf("vec%0d_rd2", i), rd2_s, tbl[i].rd2);
      chk($sformatf("vec%0d_wb_wreg", i), {31'd0, wb_wreg_o}, {31'd0, tbl[i].wbw});
      chk($sformatf("vec%0d_wb_wd", i), {27'd0, wb_wd_o}, {27'd0, tbl[i].wbd});
      chk($sformatf("vec%0d_wb_wdata", i), wb_wdata_o, tbl[i].wbdata);
    end

    // Stall: r7 sits in M for two stalled edges, then commits once.
    c7 = 0;
    cyc(st(1,0,0,0,0,0,0,0,0,0));
    cyc(st(0,1,7,32'h55,0,0,1,7,0,0));
    chk("stall_exec_fwd", rd1_s, 32'h55);
    for (int k = 0; k < 2; k++) begin
      cyc(st(0,0,0,0,1,0,1,7,0,0));
      chk("stall_m_held", rd1_s, 32'h55);
      chk("stall_w_bubble", {31'd0, wb_wreg_o}, 32'd0);
      if (wb_wreg_o && wb_wd_o == 7) c7++;
    end
    for (int k = 0; k < 3; k++) begin
      cyc(idle(1,7,0,0));
      chk("stall_r7_visible", rd1_s, 32'h55);
      if (wb_wreg_o && wb_wd_o == 7) c7++;
    end
    chk("stall_r7_commit_once", c7, 1);

    // Flush with stall: W (0xBB) still commits, M (0xAA) is dropped.
    c_aa = 0;
    cyc(st(1,0,0,0,0,0,0,0,0,0));
    cyc(st(0,1,9,32'hBB,0,0,0,0,0,0));
    cyc(st(0,1,9,32'hAA,0,0,0,0,0,0));
    chk("flush_w_before", wb_wdata_o, 32'hBB);
    cyc(st(0,0,0,0,1,1,1,9,0,0));
    chk("flush_m_fwd", rd1_s, 32'hAA);
    chk("flush_w_cleared", {31'd0, wb_wreg_o}, 32'd0);
    for (int k = 0; k < 2; k++) begin
      cyc(idle(1,9,1,9));
      chk("flush_r9_bb", rd1_s, 32'hBB);
      if (wb_wreg_o && wb_wdata_o == 32'hAA) c_aa++;
    end
    chk("flush_aa_never", c_aa, 0);
    cyc(st(1,0,0,0,0,0,1,9,0,0));
    chk("reset_rd_zero", rd1_s, 0);
    cyc(idle(1,9,0,0));
    chk("reset_r9_cleared", rd1_s, 0);

    // Random traffic on a narrow address range to exercise hazards.
    for (int k = 0; k < 600; k++) begin
      cyc(st($urandom_range(0, 39) == 0, $urandom_range(0, 1), 5'($urandom_range(0, 7)),
             $urandom, $urandom_range(0, 5) == 0, $urandom_range(0, 9) == 0,
             $urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)),
             $urandom_range(0, 3) != 0, 5'($urandom_range(0, 7))));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/wb_regfile.md
WB_REGFILE -- requirements
Module: wb_regfile

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: single clock; all state updates on rising edge.
REQ-002 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset (`RstEnable = 1'b1`).
REQ-003 The block SHALL have port wd_i, input, 5 bits: destination register address of the execute-stage result.
REQ-004 The block SHALL have port wreg_i, input, 1 bit: execute-stage write request.
REQ-005 The block SHALL have port wdata_i, input, 32 bits: execute-stage result data.
REQ-006 The block SHALL have port stall_i, input, 1 bit: hold the M stage; the W stage receives a bubble.
REQ-007 The block SHALL have port flush_i, input, 1 bit: discard the contents of the M and W stages.
REQ-008 The block SHALL have ports re1_i and re2_i, input, 1 bit each: read-port enables.
REQ-009 The block SHALL have ports raddr1_i and raddr2_i, input, 5 bits each: read-port addresses.
REQ-010 The block SHALL have ports rdata1_o and rdata2_o, output, 32 bits each: combinational read data.
REQ-011 The block SHALL have ports wb_wreg_o (1 bit), wb_wd_o (5 bits) and wb_wdata_o (32 bits), outputs: the W-stage entry committing this cycle.

Function
REQ-012 The block SHALL hold two pipeline entries, M and W, each containing {wreg, wd, wdata}; a bubble is {0, 0, 0}.
REQ-013 Each rising edge, the next-state priority SHALL be rst > flush_i > stall_i > normal.
REQ-014 Normal edge: M <= {wreg_i, wd_i, wdata_i}; W <= M.
REQ-015 Stall edge: M holds; W <= bubble.
REQ-016 Flush edge: M <= bubble; W <= bubble; flush_i overrides stall_i.
REQ-017 Commit: on every non-reset edge, if W.wreg=1 and W.wd!=0, then regs[W.wd] <= W.wdata, regardless of stall_i or flush_i.
REQ-018 Writes to register 0 SHALL be discarded; register 0 always reads 0.
REQ-019 Latency: a result presented at edge N is in M after edge N, in W after edge N+1, and in the array after edge N+2.
REQ-020 Read port k SHALL return 0 when rst=1, re_k=0, or raddr_k=0.
REQ-021 Otherwise read port k SHALL return the youngest match, in this order:
  - execute input (wreg_i=1, wd_i=raddr_k): wdata_i
  - M (M.wreg=1, M.wd=raddr_k): M.wdata
  - W (W.wreg=1, W.wd=raddr_k): W.wdata
  - otherwise: regs[raddr_k]
REQ-022 Forwarding SHALL be purely combinational with no added cycle; both ports SHALL be independent and may address the same register.
REQ-023 wb_wreg_o, wb_wd_o and wb_wdata_o SHALL equal the W-stage fields directly.

Reset
REQ-024 On a rising edge with rst=1, M, W and all 32 registers SHALL be cleared to 0, and no commit SHALL occur on that edge.
REQ-025 The wb_* outputs SHALL read 0 from the first edge after reset is asserted.
REQ-026 rdata1_o and rdata2_o SHALL be 0 while rst=1.
REQ-027 Reset asserted mid-operation SHALL discard any pending M or W writes.

Structure
REQ-028 The constants RegBus, RegAddrBus, ZeroWord, RstEnable, WriteEnable, NOPRegAddr and RegNum (32) SHALL reside in the shared defines file; no new literals.
REQ-029 The block SHALL contain one sub-module, regfile: the 32x32 array with one synchronous write port (with reset) and two combinational read ports.
REQ-030 Stage registers and forwarding muxes SHALL reside in wb_regfile.

Verification
REQ-031 Latency: drive wd=5, wreg=1, wdata=0xDEADBEEF for one cycle, then idle; wb_wdata_o=0xDEADBEEF after edge 2; after edge 3 raddr1=5 returns 0xDEADBEEF from the array.
REQ-032 Forward priority: drive r3 writes 0x11, 0x22, 0x33 on consecutive cycles; with raddr1=3 during the third cycle, rdata1_o=0x33 (execute), and after the edge 0x33 (M over W).
REQ-033 Zero register: write r0=0xFFFFFFFF; r0 reads 0 in every cycle; wb_wreg_o=1 but the array is unchanged.
REQ-034 Stall: with M holding r7=0x55, assert stall for 2 cycles; M is held, W holds a bubble after the first stalled edge, and r7=0x55 commits exactly once, later.
REQ-035 Flush and reset: with r9=0xAA in M and r9=0xBB in W, assert flush and stall together; 0xBB commits, 0xAA never commits; then a reset edge clears r9 to 0.
